target_queue_printer: RTL and testbench

TARGET_QUEUE_PRINTER -- requirements
Module: target_queue_printer

---
 rtl/target_queue_printer.sv | 229 ++++++++++++++++++++++
 tb/tb_target_queue_printer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/target_queue_printer.sv
// rtl/target_queue_printer.sv - target FIFO with hex screen printer (optional TQP_SEPARATOR_EN adds ',' between X and Y)
module target_queue_printer #(
  parameter int SLOTS      = 3,
  parameter int DIGITS     = 4,
  parameter int COORD_W    = 32,
  parameter int IDX_W      = 8,
  parameter int LIVE_BASE  = 116,
  parameter int ROW_BASE   = 176,
  parameter int ROW_STRIDE = 32
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [COORD_W-1:0] targetx,
  input  logic [COORD_W-1:0] targety,
  input  logic               queue,
  input  logic               pop,
  input  logic               start,
  output logic [IDX_W-1:0]   char_index,
  output logic [7:0]         char_data,
  output logic               char_we,
  output logic               busy,
  output logic               finish,
  output logic [3:0]         count,
  output logic               overflow
);

`ifdef TQP_SEPARATOR_EN
  localparam int SEP = 1;
`else
  localparam int SEP = 0;
`endif
  localparam int CELLS = 2 * DIGITS + SEP;
  localparam int SH_W  = (COORD_W > 1) ? $clog2(COORD_W) : 1;

  localparam logic [4:0] LAST_POS  = 5'(CELLS - 1);
  localparam logic [3:0] LAST_SLOT = 4'(SLOTS - 1);
  localparam logic [3:0] SLOTS4    = 4'(SLOTS);

  typedef enum logic [1:0] {IDLE, LIVE, QUEUE, DONE} state_t;

  state_t state, n_state;
  logic [4:0] pos, n_pos;
  logic [3:0] slot, n_slot;
  logic       n_emit, n_last;
  logic [IDX_W-1:0] n_index;
  logic [7:0]       n_data;

  logic [3:0] head, tail;
  logic [COORD_W-1:0] x_mem [SLOTS];
  logic [COORD_W-1:0] y_mem [SLOTS];

  logic queue_d1, queue_d2, pop_d1, pop_d2;
  logic push_ev, pop_ev, do_pop;

  function automatic logic [3:0] ptr_inc(input logic [3:0] p);
    return (p == LAST_SLOT) ? 4'd0 : p + 4'd1;
  endfunction

  // Registered copies of queue/pop for rising-edge detection
  always_ff @(posedge clock) begin
    if (!resetn) begin
      queue_d1 <= 1'b0;
      queue_d2 <= 1'b0;
      pop_d1   <= 1'b0;
      pop_d2   <= 1'b0;
    end else begin
      queue_d1 <= queue;
      queue_d2 <= queue_d1;
      pop_d1   <= pop;
      pop_d2   <= pop_d1;
    end
  end

  assign push_ev = queue_d1 & ~queue_d2;
  assign pop_ev  = pop_d1 & ~pop_d2;
  assign do_pop  = pop_ev && (count != 4'd0);

  // Slot storage: a push always lands at the tail, even when it overwrites the oldest
  always_ff @(posedge clock) begin
    for (int k = 0; k < SLOTS; k++) begin
      if (push_ev && tail == 4'(k)) begin
        x_mem[k] <= targetx;
        y_mem[k] <= targety;
      end
    end
  end

  // Head/tail/count bookkeeping and overflow pulse
  always_ff @(posedge clock) begin
    if (!resetn) begin
      head     <= 4'd0;
      tail     <= 4'd0;
      count    <= 4'd0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (push_ev) begin
        tail <= ptr_inc(tail);
      end
      if (push_ev && do_pop) begin
        head <= ptr_inc(head);
      end else if (push_ev) begin
        if (count == SLOTS4) begin
          head     <= ptr_inc(head);
          overflow <= 1'b1;
        end else begin
          count <= count + 4'd1;
        end
      end else if (do_pop) begin
        head  <= ptr_inc(head);
        count <= count - 4'd1;
      end
    end
  end

  // Sequencer: decide which cell (if any) is written in the coming cycle
  always_comb begin
    n_state = state;
    n_pos   = pos;
    n_slot  = slot;
    n_emit  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          n_state = LIVE;
          n_pos   = 5'd0;
          n_slot  = 4'd0;
          n_emit  = 1'b1;
        end
      end
      LIVE: begin
        n_emit = 1'b1;
        if (pos == LAST_POS) begin
          n_state = QUEUE;
          n_pos   = 5'd0;
          n_slot  = 4'd0;
        end else begin
          n_pos = pos + 5'd1;
        end
      end
      QUEUE: begin
        n_emit = 1'b1;
        if (pos == LAST_POS) begin
          if (slot == LAST_SLOT) begin
            n_state = DONE;
            n_emit  = 1'b0;
          end else begin
            n_slot = slot + 4'd1;
            n_pos  = 5'd0;
          end
        end else begin
          n_pos = pos + 5'd1;
        end
      end
      default: n_state = IDLE;
    endcase
    n_last = n_emit && (n_state == QUEUE) && (n_slot == LAST_SLOT) && (n_pos == LAST_POS);
  end

  // Character generation for the upcoming cell, reading slot storage by age order
  always_comb begin
    logic [3:0]         phys;
    logic [COORD_W-1:0] sel_x, sel_y;
    logic               valid, is_x, is_sep;
    logic [31:0]        base;
    int                 p, dig, off;
    logic [SH_W-1:0]    sh;
    logic [3:0]         nib;
    logic [7:0]         hexc;

    phys = head + n_slot;
    if (phys >= SLOTS4) phys = phys - SLOTS4;
    sel_x = targetx;
    sel_y = targety;
    valid = 1'b1;
    base  = 32'(LIVE_BASE);
    if (n_state == QUEUE) begin
      for (int k = 0; k < SLOTS; k++) begin
        if (phys == 4'(k)) begin
          sel_x = x_mem[k];
          sel_y = y_mem[k];
        end
      end
      valid = (n_slot < count);
      base  = 32'(ROW_BASE) + 32'(n_slot) * 32'(ROW_STRIDE);
    end

    p      = int'(n_pos);
    is_x   = (p < DIGITS);
    is_sep = (SEP == 1) && (p == DIGITS);
    dig    = is_x ? p : p - DIGITS - SEP;
    if (dig < 0) dig = 0;
    off    = (is_x || SEP == 1) ? p : p + 1;
    sh     = SH_W'(4 * (DIGITS - 1 - dig));
    nib    = is_x ? sel_x[sh +: 4] : sel_y[sh +: 4];
    hexc   = (nib < 4'd10) ? {4'h3, nib} : 8'h37 + {4'h0, nib};

    if (is_sep)      n_data = 8'h2C;
    else if (!valid) n_data = 8'h2D;
    else             n_data = hexc;
    n_index = IDX_W'(base + 32'(off));
  end

  // FSM state and registered write-port outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      pos        <= 5'd0;
      slot       <= 4'd0;
      char_index <= IDX_W'(LIVE_BASE);
      char_data  <= 8'h00;
      char_we    <= 1'b0;
      busy       <= 1'b0;
      finish     <= 1'b0;
    end else begin
      state   <= n_state;
      pos     <= n_pos;
      slot    <= n_slot;
      char_we <= n_emit;
      busy    <= n_emit;
      finish  <= n_last;
      if (n_emit) begin
        char_index <= n_index;
        char_data  <= n_data;
      end
    end
  end

endmodule

// File: tb/tb_target_queue_printer.sv
// tb/tb_target_queue_printer.sv - directed vector bench for target_queue_printer
module tb_target_queue_printer;

  localparam int SLOTS  = 3;
  localparam int DIGITS = 4;
`ifdef TQP_SEPARATOR_EN
  localparam int SEP = 1;
`else
  localparam int SEP = 0;
`endif
  localparam int CELLS = 2 * DIGITS + SEP;
  localparam int PASS_LEN = (SLOTS + 1) * CELLS;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] targetx = '0;
  logic [31:0] targety = '0;
  logic        queue = 1'b0;
  logic        pop = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  char_index;
  logic [7:0]  char_data;
  logic        char_we;
  logic        busy;
  logic        finish;
  logic [3:0]  count;
  logic        overflow;

  target_queue_printer #(
    .SLOTS(SLOTS), .DIGITS(DIGITS), .COORD_W(32), .IDX_W(8),
    .LIVE_BASE(116), .ROW_BASE(176), .ROW_STRIDE(32)
  ) dut (
    .clock(clock), .resetn(resetn), .targetx(targetx), .targety(targety),
    .queue(queue), .pop(pop), .start(start), .char_index(char_index),
    .char_data(char_data), .char_we(char_we), .busy(busy), .finish(finish),
    .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  int wr_idx[$];
  int wr_dat[$];
  int fin_cnt = 0;
  int fin_at  = -1;
  int ovf_cnt = 0;
  int bad_busy = 0;
  int exp_idx[$];
  int exp_dat[$];

  typedef struct { logic [31:0] x; logic [31:0] y; } ent_t;
  ent_t mq[$];

  typedef struct {
    logic        q;
    logic        p;
    logic [31:0] x;
    logic [31:0] y;
    int          exp_count;
    int          exp_ovf;
  } vec_t;
  vec_t vecs[11];

  always @(negedge clock) begin
    if (char_we) begin
      wr_idx.push_back(int'(char_index));
      wr_dat.push_back(int'(char_data));
      if (!busy) bad_busy++;
    end
    if (finish) begin
      fin_cnt++;
      fin_at = wr_idx.size();
      if (!char_we) bad_busy++;
    end
    if (overflow) ovf_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s actual=%0h required=%0h", name, act, req);
    else passed++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int hexd(input logic [31:0] v, input int d);
    logic [31:0] nib;
    nib = (v >> (4 * (DIGITS - 1 - d))) & 32'hF;
    return (nib < 10) ? 48 + int'(nib) : 55 + int'(nib);
  endfunction

  task automatic apply_op(input logic q, input logic p, input logic [31:0] x, input logic [31:0] y);
    ent_t e;
    e.x = x;
    e.y = y;
    targetx = x;
    targety = y;
    ovf_cnt = 0;
    queue = q;
    pop = p;
    repeat (2) step();
    queue = 1'b0;
    pop = 1'b0;
    repeat (4) step();
    if (q && p) begin
      if (mq.size() != 0) void'(mq.pop_front());
      mq.push_back(e);
    end else if (q) begin
      if (mq.size() == SLOTS) void'(mq.pop_front());
      mq.push_back(e);
    end else if (p) begin
      if (mq.size() != 0) void'(mq.pop_front());
    end
  endtask

  task automatic build_expected(input logic [31:0] lx, input logic [31:0] ly);
    exp_idx.delete();
    exp_dat.delete();
    for (int r = 0; r <= SLOTS; r++) begin
      int b;
      logic v;
      logic [31:0] cx, cy;
      b  = (r == 0) ? 116 : 176 + (r - 1) * 32;
      v  = (r == 0) || (r - 1 < mq.size());
      cx = (r == 0) ? lx : (v ? mq[r-1].x : 32'h0);
      cy = (r == 0) ? ly : (v ? mq[r-1].y : 32'h0);
      for (int d = 0; d < DIGITS; d++) begin
        exp_idx.push_back((b + d) & 255);
        exp_dat.push_back(v ? hexd(cx, d) : 8'h2D);
      end
      if (SEP == 1) begin
        exp_idx.push_back((b + DIGITS) & 255);
        exp_dat.push_back(8'h2C);
      end
      for (int d = 0; d < DIGITS; d++) begin
        exp_idx.push_back((b + DIGITS + 1 + d) & 255);
        exp_dat.push_back(v ? hexd(cy, d) : 8'h2D);
      end
    end
  endtask

  task automatic run_pass(input string tag, input logic [31:0] lx, input logic [31:0] ly);
    logic done;
    int   bad;
    targetx = lx;
    targety = ly;
    build_expected(lx, ly);
    wr_idx.delete();
    wr_dat.delete();
    fin_cnt = 0;
    fin_at = -1;
    bad_busy = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (!busy && wr_idx.size() > 0) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, "_completes"}, 32'(done), 32'd1);
    check({tag, "_len"}, 32'(wr_idx.size()), 32'(PASS_LEN));
    bad = -1;
    for (int i = 0; i < PASS_LEN && i < wr_idx.size(); i++) begin
      if (bad < 0 && (wr_idx[i] != exp_idx[i] || wr_dat[i] != exp_dat[i])) bad = i;
    end
    if (bad >= 0)
      $display("FAIL %s_content write %0d actual idx=%0d data=%0h required idx=%0d data=%0h",
               tag, bad, wr_idx[bad], wr_dat[bad], exp_idx[bad], exp_dat[bad]);
    total++;
    if (bad < 0) passed++;
    check({tag, "_finish_cnt"}, 32'(fin_cnt), 32'd1);
    check({tag, "_finish_at"}, 32'(fin_at), 32'(PASS_LEN));
    check({tag, "_busy_we"}, 32'(bad_busy), 32'd0);
    step();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h0, 32'h0, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_1A2B, 32'h0000_3C4D, 1, 0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_5E6F, 32'h0000_7081, 2, 0};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_9293, 32'h0000_A4B5, 2, 0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_C6D7, 32'h0000_E8F9, 3, 0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0F1E, 32'h0000_2D3C, 3, 1};
    vecs[6]  = '{1'b0, 1'b1, 32'h0, 32'h0, 2, 0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0, 32'h0, 1, 0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0, 32'h0, 0, 0};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_4B5A, 32'h0000_6978, 1, 0};
    vecs[10] = '{1'b0, 1'b1, 32'h0, 32'h0, 0, 0};

    resetn = 1'b0;
    repeat (3) step();
    @(negedge clock);
    check("rst_char_index", 32'(char_index), 32'd116);
    check("rst_char_data", 32'(char_data), 32'd0);
    check("rst_char_we", 32'(char_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    step();
    resetn = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      apply_op(vecs[i].q, vecs[i].p, vecs[i].x, vecs[i].y);
      @(negedge clock);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_overflow", i), 32'(ovf_cnt), 32'(vecs[i].exp_ovf));
      step();
    end

    // Empty queue: all slot cells print '-'
    run_pass("empty", 32'h1234_5678, 32'h9ABC_DEF0);
    check("empty_first_idx", 32'(wr_idx[0]), 32'd116);
    check("empty_first_data", 32'(wr_dat[0]), 32'h35);
    check("empty_last_slot_cell", 32'(wr_dat[PASS_LEN-1]), 32'h2D);
`ifdef TQP_SEPARATOR_EN
    check("sep_live_idx", 32'(wr_idx[DIGITS]), 32'd120);
    check("sep_live_data", 32'(wr_dat[DIGITS]), 32'h2C);
`endif

    // One entry with distinctive nibbles
    apply_op(1'b1, 1'b0, 32'h0A0B_0C0D, 32'h0102_0304);
    run_pass("one", 32'h0000_FFFF, 32'h0000_0000);
    check("one_slot0_idx", 32'(wr_idx[CELLS]), 32'd176);
    check("one_slot0_d0", 32'(wr_dat[CELLS]), 32'h30);
    check("one_slot0_d1", 32'(wr_dat[CELLS+1]), 32'h43);
    check("one_slot0_d2", 32'(wr_dat[CELLS+2]), 32'h30);
    check("one_slot0_d3", 32'(wr_dat[CELLS+3]), 32'h44);
    check("one_slot0_y_idx", 32'(wr_idx[CELLS+DIGITS+SEP]), 32'd181);
    check("one_live_x_f", 32'(wr_dat[0]), 32'h46);

    // Four pushes into three slots: single overflow, second push becomes oldest
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    mq.delete();
    step();
    apply_op(1'b1, 1'b0, 32'h0000_1111, 32'h0000_AAAA);
    apply_op(1'b1, 1'b0, 32'h0000_2222, 32'h0000_BBBB);
    apply_op(1'b1, 1'b0, 32'h0000_3333, 32'h0000_CCCC);
    ovf_cnt = 0;
    apply_op(1'b1, 1'b0, 32'h0000_4444, 32'h0000_DDDD);
    @(negedge clock);
    check("ovf4_count", 32'(count), 32'd3);
    check("ovf4_pulses", 32'(ovf_cnt), 32'd1);
    step();
    run_pass("ovf4", 32'h0000_0000, 32'h0000_0000);
    check("ovf4_slot0_data", 32'(wr_dat[CELLS]), 32'h32);
    check("ovf4_slot2_data", 32'(wr_dat[3*CELLS]), 32'h34);

    // Reset in the middle of a pass
    begin
      logic reached;
      reached = 1'b0;
      wr_idx.delete();
      wr_dat.delete();
      fin_cnt = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clock);
        #1;
        if (wr_idx.size() >= 10) begin
          reached = 1'b1;
          break;
        end
      end
      check("midrst_reached_w10", 32'(reached), 32'd1);
      resetn = 1'b0;
      @(negedge clock);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_char_we", 32'(char_we), 32'd0);
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_finish", 32'(finish), 32'd0);
      resetn = 1'b1;
      mq.delete();
      repeat (5) step();
      check("midrst_no_finish", 32'(fin_cnt), 32'd0);
      check("midrst_stays_idle", 32'(busy), 32'd0);
    end

    repeat (2) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
